// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit path.
// Launch FSM encodings, default queue depth and byte width.
package uart_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int TXQ_DEPTH_LOG2 = 4;

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] WAIT_ACT  = 2'b01;
  localparam logic [1:0] WAIT_DONE = 2'b10;
  localparam logic [1:0] GAP       = 2'b11;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: byte register array for the transmit queue.
// Synchronous write, asynchronous read, contents never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2
) (
  input  logic                   i_Clock,
  input  logic                   i_Wr_En,
  input  logic [DEPTH_LOG2-1:0]  i_Wr_Addr,
  input  logic [UART_BYTE_W-1:0] i_Wr_Data,
  input  logic [DEPTH_LOG2-1:0]  i_Rd_Addr,
  output logic [UART_BYTE_W-1:0] o_Rd_Data
);

  logic [UART_BYTE_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) mem[i_Wr_Addr] <= i_Wr_Data;
  end

  assign o_Rd_Data = mem[i_Rd_Addr];

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO and frame launch control ahead of the UART TX.
// Define UART_TXQ_FLUSH_EN to add the i_Flush queue-discard input.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_H,
`ifdef UART_TXQ_FLUSH_EN
  input  logic                   i_Flush,
`endif
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Data,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [DEPTH_LOG2:0]    o_Count,
  output logic                   o_Overflow,
  output logic                   o_TX_DV,
  output logic [UART_BYTE_W-1:0] o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic                   o_Busy
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic [DEPTH_LOG2:0]    count_nxt;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [UART_BYTE_W-1:0] rd_data;
  logic                   flush;
  logic                   wr_ok;
  logic                   launch;

`ifdef UART_TXQ_FLUSH_EN
  assign flush = i_Flush;
`else
  assign flush = 1'b0;
`endif

  // Full is the registered flag, so a pop in the same cycle cannot rescue a write.
  assign wr_ok  = i_Wr_En & ~o_Full & ~flush;
  assign launch = (state == IDLE) & ~o_Empty &
                  ~i_TX_Active & ~i_TX_Done;

  uart_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .i_Clock   (i_Clock),
    .i_Wr_En   (wr_ok),
    .i_Wr_Addr (wr_ptr),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_Addr (rd_ptr),
    .o_Rd_Data (rd_data)
  );

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      flush:                     count_nxt = '0;
      wr_ok & ~launch:           count_nxt = count + 1'b1;
      ~flush & launch & ~wr_ok:  count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (launch) state_nxt = WAIT_ACT;
      WAIT_ACT:  if (i_TX_Active) state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_TX_Done) state_nxt = GAP;
      GAP:       if (!i_TX_Done && !i_TX_Active) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst_H) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      o_Full     <= (count_nxt == FULL_CNT);
      o_Empty    <= (count_nxt == '0);
      o_Overflow <= i_Wr_En & o_Full & ~flush;
      o_TX_DV    <= launch;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (flush) rd_ptr <= wr_ptr;
      else if (launch) rd_ptr <= rd_ptr + 1'b1;
      if (launch) o_TX_Byte <= rd_data;
    end
  end

  assign o_Count = count;
  assign o_Busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: randomized bench with a UART transmitter model,
// a serial-line receiver and a queue-level reference model.
module tb_uart_tx_queue;

  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int CPB   = 4;

  logic clk = 1'b0;
  logic rst, flush, wr_en, tx_hold;
  logic tx_active, tx_done, tx_serial;
  logic [7:0] wr_data;
  logic full, empty, ovf, dv, busy;
  logic [7:0] tx_byte;
  logic [DL:0] cnt;

  int n_checks = 0;
  int n_fail = 0;
  int occ = 0;
  int max_cnt = 0;
  int dv_pulses = 0;
  int tx_t = 0;
  logic [7:0] ref_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
    .i_Clock     (clk),
    .i_Rst_H     (rst),
`ifdef UART_TXQ_FLUSH_EN
    .i_Flush     (flush),
`endif
    .i_Wr_En     (wr_en),
    .i_Wr_Data   (wr_data),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (cnt),
    .o_Overflow  (ovf),
    .o_TX_DV     (dv),
    .o_TX_Byte   (tx_byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done),
    .o_Busy      (busy)
  );

  // Transmitter: start bit, 8 data bits LSB first, stop bit, 2-cycle Done.
  initial begin : tx_model
    logic [9:0] fr;
    fr = '1;
    tx_active = 1'b0;
    tx_done = 1'b0;
    tx_serial = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_t = 0; tx_active = 1'b0; tx_done = 1'b0; tx_serial = 1'b1;
      end else if (tx_t == 0) begin
        tx_active = 1'b0; tx_done = 1'b0; tx_serial = 1'b1;
        if (dv) begin fr = {1'b1, tx_byte, 1'b0}; tx_t = 1; end
      end else if (tx_t == 1 && tx_hold) begin
        tx_active = 1'b1;
      end else if (tx_t <= 10*CPB) begin
        tx_active = 1'b1; tx_serial = fr[(tx_t-1)/CPB]; tx_t++;
      end else if (tx_t <= 10*CPB+2) begin
        tx_active = 1'b0; tx_done = 1'b1; tx_serial = 1'b1; tx_t++;
      end else begin
        tx_done = 1'b0; tx_t = 0;
      end
    end
  end

  initial begin : rx_mon
    logic [7:0] b;
    b = '0;
    forever begin
      @(posedge clk);
      if (tx_serial === 1'b0) begin
        repeat (CPB/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          b[i] = tx_serial;
        end
        repeat (CPB) @(posedge clk);
        rx_q.push_back(b);
      end
    end
  end

  // Queue reference: occupancy and byte order from accepted writes and launches.
  initial begin : monitor
    logic w, r, a, d, f, dvp, acc, eovf;
    logic [7:0] wd, b;
    int occ0;
    dvp = 1'b0;
    forever begin
      @(posedge clk);
      w = wr_en; wd = wr_data; r = rst;
      a = tx_active; d = tx_done; f = flush;
      #1;
      eovf = 1'b0;
      if (r) begin
        occ = 0; ref_q.delete(); dvp = 1'b0;
        n_checks++;
        if (dv !== 1'b0 || busy !== 1'b0 || tx_byte !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_out got dv=%b busy=%b byte=%h want 0 0 00",
                   dv, busy, tx_byte);
        end
      end else begin
        occ0 = occ;
        acc = w && !f && (occ0 < DEPTH);
        eovf = w && !f && (occ0 == DEPTH);
        if (dv === 1'b1) begin
          n_checks++;
          if (occ0 == 0 || a || d || dvp) begin
            n_fail++;
            $display("FAIL launch_legal got occ=%0d act=%b done=%b prev_dv=%b want occ>0 0 0 0",
                     occ0, a, d, dvp);
          end else begin
            b = ref_q.pop_front();
            exp_rx.push_back(b);
            occ--; dv_pulses++;
            n_checks++;
            if (tx_byte !== b) begin
              n_fail++;
              $display("FAIL launch_byte got=%h want=%h", tx_byte, b);
            end
          end
        end
        if (acc) begin ref_q.push_back(wd); occ++; end
        if (f) begin occ = 0; ref_q.delete(); end
        dvp = dv;
      end
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      n_checks++;
      if (cnt !== (DL+1)'(occ) || full !== (occ == DEPTH) ||
          empty !== (occ == 0) || ovf !== eovf) begin
        n_fail++;
        $display("FAIL queue_state got cnt=%0d full=%b empty=%b ovf=%b want %0d %b %b %b",
                 cnt, full, empty, ovf, occ, occ == DEPTH, occ == 0, eovf);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 3000 && !(occ == 0 && busy === 1'b0 && tx_t == 0 &&
                         rx_q.size() == exp_rx.size())) begin
      @(posedge clk); #2; k++;
    end
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s_drain got occ=%0d rx=%0d want occ=0 rx=%0d",
               name, occ, rx_q.size(), exp_rx.size());
    end else begin
      for (int i = 0; i < exp_rx.size(); i++) begin
        n_checks++;
        if (rx_q[i] !== exp_rx[i]) begin
          n_fail++;
          $display("FAIL %s_rx%0d got=%h want=%h", name, i, rx_q[i], exp_rx[i]);
        end
      end
    end
    rx_q.delete();
    exp_rx.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    n_checks++;
    if (cnt !== '0 || empty !== 1'b1 || full !== 1'b0 || dv !== 1'b0 ||
        busy !== 1'b0 || ovf !== 1'b0 || tx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset got cnt=%0d e=%b f=%b dv=%b busy=%b ovf=%b byte=%h want 0 1 0 0 0 0 00",
               cnt, empty, full, dv, busy, ovf, tx_byte);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single;
    int k;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(posedge clk); #2;
    n_checks++;
    if (dv !== 1'b0 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1 got dv=%b empty=%b want 0 0", dv, empty);
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (dv !== 1'b1 || tx_byte !== 8'hA5 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_launch got dv=%b byte=%h empty=%b want 1 a5 1",
               dv, tx_byte, empty);
    end
    @(posedge clk); #2;
    n_checks++;
    if (dv !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pulse got dv=%b busy=%b want 0 1", dv, busy);
    end
    k = 0;
    while (tx_done !== 1'b1 && k < 200) begin @(posedge clk); #2; k++; end
    while (tx_done === 1'b1 && k < 400) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_busy_done got=%b want=1", busy);
      end
      @(posedge clk); #2; k++;
    end
    n_checks++;
    if (busy !== 1'b0 || tx_byte !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_end got busy=%b byte=%h want 0 a5", busy, tx_byte);
    end
    drain("single");
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = dv_pulses;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    drain("burst");
    n_checks++;
    if (dv_pulses - p0 != 5) begin
      n_fail++;
      $display("FAIL burst_dv_count got=%0d want=5", dv_pulses - p0);
    end
  endtask

  task automatic test_full_overflow;
    int p0;
    p0 = dv_pulses;
    tx_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (full !== 1'b1 || cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL full got full=%b cnt=%0d want 1 4", full, cnt);
    end
    @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
    @(posedge clk); #2;
    n_checks++;
    if (ovf !== 1'b1 || cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow got ovf=%b cnt=%0d want 1 4", ovf, cnt);
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_pulse got=%b want=0", ovf);
    end
    @(negedge clk); tx_hold = 1'b0;
    drain("full");
    n_checks++;
    if (dv_pulses - p0 != 5) begin
      n_fail++;
      $display("FAIL full_dv_count got=%0d want=5", dv_pulses - p0);
    end
  endtask

  task automatic test_wrap;
    int p0, k;
    p0 = dv_pulses;
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      k = 0;
      while (full !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      @(negedge clk); wr_en = 1'b0;
    end
    drain("wrap");
    n_checks++;
    if (dv_pulses - p0 != 10 || max_cnt > DEPTH) begin
      n_fail++;
      $display("FAIL wrap got dv=%0d maxcnt=%0d want 10 <=%0d",
               dv_pulses - p0, max_cnt, DEPTH);
    end
  endtask

  task automatic test_reset_midframe;
    int k;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
    end
    @(negedge clk); wr_en = 1'b0;
    k = 0;
    while (!(tx_active === 1'b1 && busy === 1'b1) && k < 200) begin
      @(posedge clk); #2; k++;
    end
    n_checks++;
    if (k >= 200 || cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL midframe_setup got cnt=%0d wait=%0d want 3 <200", cnt, k);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    n_checks++;
    if (cnt !== '0 || empty !== 1'b1 || dv !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset got cnt=%0d e=%b dv=%b busy=%b want 0 1 0 0",
               cnt, empty, dv, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    rx_q.delete();
    exp_rx.delete();
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_en = 1'b0;
    drain("midframe");
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
    end
    @(negedge clk); wr_en = 1'b0;
    drain("random");
  endtask

`ifdef UART_TXQ_FLUSH_EN
  task automatic test_flush;
    int p0;
    p0 = dv_pulses;
    tx_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
    end
    @(negedge clk); flush = 1'b1; wr_data = 8'($urandom);
    @(posedge clk); #2;
    n_checks++;
    if (cnt !== '0 || empty !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL flush got cnt=%0d e=%b ovf=%b want 0 1 0", cnt, empty, ovf);
    end
    @(negedge clk); flush = 1'b0; wr_en = 1'b0; tx_hold = 1'b0;
    drain("flush");
    n_checks++;
    if (dv_pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL flush_dv_count got=%0d want=1", dv_pulses - p0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    tx_hold = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_wrap();
    test_reset_midframe();
    test_random();
`ifdef UART_TXQ_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
